apb_wait_slave: RTL and testbench

- Clocked APB slave with an 8-bit register-file memory and a programmable number of wait states.
- Sits directly downstream of apb_master, as a drop-in for either slave position (PSEL1 or PSEL2 side) in apb_top. It takes PADDR[7:0].
- Exercises the master's PREADY-stall path and its PSLVERR path. It adds real wait-state timing, an out-of-range error response and abort handling on protocol violations.

---
 rtl/apb_wait_slave.sv | 137 +++++++++++++
 tb/tb_apb_wait_slave.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB slave with a small register-file memory and a fixed
// number of wait states per transfer. It flags addresses outside the memory
// with PSLVERR and abandons a transfer when the master drops PSEL/PENABLE
// early. PRDATA, PREADY and PSLVERR all come straight from flops.
module apb_wait_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int MEM_DEPTH   = 192,
    parameter int WAIT_STATES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [3:0]          WS_L    = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wr_q, err_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  pready_n, pslverr_n;
    logic [DATA_WIDTH-1:0] prdata_n;
    logic                  latch_en, mem_we, in_err;

    // The range check compares with one spare bit, so an address that is
    // out of range can never fold back onto a valid word.
    assign in_err = ({1'b0, PADDR} >= DEPTH_L);

    // State, wait counter and registered outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            PREADY  <= pready_n;
            PSLVERR <= pslverr_n;
            PRDATA  <= prdata_n;
        end
    end

    // Next state and next output values. The outputs fall to 0 by default,
    // so they are only non-zero for the single completing cycle.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pready_n  = 1'b0;
        pslverr_n = 1'b0;
        prdata_n  = '0;
        latch_en  = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                // Only a real setup phase starts a transfer. PSEL together
                // with PENABLE and no setup cycle before it is ignored.
                if (PSEL && !PENABLE) begin
                    latch_en = 1'b1;
                    state_n  = ACCESS;
                    cnt_n    = WS_L;
                    if (WS_L == 4'd0) begin
                        pready_n  = 1'b1;
                        pslverr_n = in_err;
                        if (!PWRITE && !in_err)
                            prdata_n = mem[PADDR];
                    end
                end
            end
            ACCESS: begin
                if (PREADY) begin
                    // Completing edge: commit the write, then go back to idle.
                    mem_we  = wr_q && !err_q;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (!PSEL || !PENABLE) begin
                    // The master quit before completion, so drop the transfer.
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt <= 4'd1) begin
                    cnt_n     = '0;
                    pready_n  = 1'b1;
                    pslverr_n = err_q;
                    if (!wr_q && !err_q)
                        prdata_n = mem[addr_q];
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Transfer attributes captured in the setup phase and held until the
    // transfer ends.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (latch_en) begin
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            wr_q    <= PWRITE;
            err_q   <= in_err;
        end
    end

    // Memory array. Reset clears every word.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                mem[i] <= '0;
        end else if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_wait_slave.sv
// tb_apb_wait_slave: drives two slaves, one with two wait states and one
// with none. Each transfer pushes its expected completion onto a
// scoreboard. The entry is popped and compared when PREADY rises.
module tb_apb_wait_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       psel0, pselz, pen, pwr;
    logic [7:0] paddr, pwdata;
    logic [7:0] rd0, rdz;
    logic       rdy0, rdyz, err0, errz;

    always #5 clk = ~clk;

    apb_wait_slave #(.WAIT_STATES(2)) dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(pen), .PWRITE(pwr),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(rd0), .PREADY(rdy0), .PSLVERR(err0));

    apb_wait_slave #(.WAIT_STATES(0)) dutz (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(pselz), .PENABLE(pen), .PWRITE(pwr),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(rdz), .PREADY(rdyz), .PSLVERR(errz));

    typedef struct {
        int         cyc;
        logic       err;
        logic [7:0] data;
        bit         chk_data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m0 [256];
    logic [7:0] mz [256];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin
            m0[i] = 8'h00;
            mz[i] = 8'h00;
        end
    endtask

    // One complete transfer on slave z (1 = zero wait states) or slave 0.
    // PADDR and PWDATA are scrambled during the access phase, so any use of
    // them after setup shows up as a wrong result.
    task automatic xfer(input bit z, input bit wr, input logic [7:0] a, input logic [7:0] d);
        exp_t       e;
        int         cyc;
        logic       r;
        logic [7:0] rd;
        logic       er;
        e.cyc      = z ? 1 : 3;
        e.err      = (a >= 8'd192);
        e.data     = 8'h00;
        e.chk_data = !(wr && e.err);
        if (!wr && !e.err) e.data = z ? mz[a] : m0[a];
        if (wr && !e.err) begin
            if (z) mz[a] = d;
            else   m0[a] = d;
        end
        sb.push_back(e);
        @(negedge clk);
        psel0 = !z; pselz = z; pen = 1'b0; pwr = wr; paddr = a; pwdata = d;
        @(negedge clk);
        pen = 1'b1; paddr = ~a; pwdata = ~d;
        cyc = 1;
        forever begin
            r  = z ? rdyz : rdy0;
            rd = z ? rdz : rd0;
            er = z ? errz : err0;
            if (r) break;
            if (cyc >= 20) break;
            cyc++;
            @(negedge clk);
        end
        e = sb.pop_front();
        if (!r) chk("timeout_pready", 32'(r), 32'd1);
        else begin
            chk("ready_cycle", 32'(cyc), 32'(e.cyc));
            chk("pslverr", 32'(er), 32'(e.err));
            if (e.chk_data) chk("prdata", 32'(rd), 32'(e.data));
        end
        @(negedge clk);
        psel0 = 1'b0; pselz = 1'b0; pen = 1'b0;
        chk("idle_pready", 32'(z ? rdyz : rdy0), 32'd0);
        chk("idle_prdata", 32'(z ? rdz : rd0), 32'd0);
    endtask

    initial begin
        psel0 = 0; pselz = 0; pen = 0; pwr = 0; paddr = 0; pwdata = 0;
        clear_model();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pready0", 32'(rdy0), 0);
        chk("rst_pslverr0", 32'(err0), 0);
        chk("rst_prdata0", 32'(rd0), 0);
        chk("rst_preadyz", 32'(rdyz), 0);
        rst_n = 1'b1;

        // Reset then read, followed by a write and a read back.
        xfer(0, 0, 8'h05, 8'h00);
        xfer(0, 1, 8'h10, 8'hA5);
        xfer(0, 0, 8'h10, 8'h00);

        // Out of range, plus the last valid word.
        xfer(0, 1, 8'hC0, 8'h3C);
        xfer(0, 0, 8'hC0, 8'h00);
        xfer(0, 0, 8'hBF, 8'h00);
        xfer(0, 1, 8'hFF, 8'h12);
        xfer(0, 0, 8'h3F, 8'h00);

        // Zero wait states.
        xfer(1, 1, 8'h01, 8'h77);
        xfer(1, 0, 8'h01, 8'h00);
        xfer(1, 0, 8'hC5, 8'h00);
        xfer(0, 0, 8'h01, 8'h00);

        // Random transfers on both slaves.
        for (int i = 0; i < 24; i++)
            xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 199)), 8'($urandom));

        // Abort: PSEL drops in access cycle 1.
        @(negedge clk);
        psel0 = 1; pen = 0; pwr = 1; paddr = 8'h20; pwdata = 8'hFF;
        @(negedge clk);
        pen = 1; psel0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_pready", 32'(rdy0), 0);
        end
        pen = 0;
        xfer(0, 0, 8'h20, 8'h00);

        // Stray PENABLE in IDLE with no setup cycle.
        @(negedge clk);
        psel0 = 1; pen = 1; pwr = 0; paddr = 8'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stray_pready", 32'(rdy0), 0);
        end
        psel0 = 0; pen = 0;
        xfer(0, 0, 8'h10, 8'h00);

        // Reset in access cycle 2 of a write.
        @(negedge clk);
        psel0 = 1; pen = 0; pwr = 1; paddr = 8'h30; pwdata = 8'h55;
        @(negedge clk);
        pen = 1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_pready", 32'(rdy0), 0);
        chk("midrst_pslverr", 32'(err0), 0);
        chk("midrst_prdata", 32'(rd0), 0);
        psel0 = 0; pen = 0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 0, 8'h30, 8'h00);
        xfer(0, 0, 8'h10, 8'h00);
        xfer(1, 0, 8'h01, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
